// File: rtl/kpt_out_streamer_if.sv
// Output stream handshake for kpt_out_streamer: a word moves when out_valid and out_ready are both high.
interface kpt_out_streamer_if;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/kpt_out_streamer.sv
// Dumps the layer-1 and layer-2 keypoint memories as a 16-bit valid/ready word stream.
// Optional macro KPT_STREAM_CHECKSUM_EN appends a running XOR trailer word after layer 2.
module kpt_out_streamer #(
    parameter int unsigned MAX_KP = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [12:0]               kp1_num,
    input  logic [12:0]               kp2_num,
    output logic [11:0]               kp1_addr,
    output logic [11:0]               kp2_addr,
    input  logic [18:0]               kp1_rdata,
    input  logic [18:0]               kp2_rdata,
    kpt_out_streamer_if.master        out_if,
    output logic                      busy,
    output logic                      done
);

    localparam logic [12:0] MAX_NUM = 13'(MAX_KP);

    typedef enum logic [3:0] {
        IDLE, HDR1, RD1, ROW1, COL1, HDR2, RD2, ROW2, COL2,
`ifdef KPT_STREAM_CHECKSUM_EN
        TRL,
`endif
        FIN
    } state_t;

    state_t      state, state_n;
    logic [12:0] n1_q, n2_q;
    logic [9:0]  col_q;
    logic        xfer, last1, last2;
`ifdef KPT_STREAM_CHECKSUM_EN
    logic [15:0] csum_q;
`endif

    function automatic logic [12:0] sat(input logic [12:0] n);
        return (n > MAX_NUM) ? MAX_NUM : n;
    endfunction

    assign xfer  = out_if.out_valid && out_if.out_ready;
    assign last1 = ({1'b0, kp1_addr} == (n1_q - 13'd1));
    assign last2 = ({1'b0, kp2_addr} == (n2_q - 13'd1));
    assign busy  = (state != IDLE) && (state != FIN);
    assign done  = (state == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            n1_q     <= '0;
            n2_q     <= '0;
            col_q    <= '0;
            kp1_addr <= '0;
            kp2_addr <= '0;
`ifdef KPT_STREAM_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                n1_q     <= sat(kp1_num);
                n2_q     <= sat(kp2_num);
                kp1_addr <= '0;
                kp2_addr <= '0;
`ifdef KPT_STREAM_CHECKSUM_EN
                csum_q   <= '0;
`endif
            end
            // rdata stays stable while ROW stalls, so the column is re-captured each ROW cycle
            if (state == ROW1) col_q <= kp1_rdata[9:0];
            if (state == ROW2) col_q <= kp2_rdata[9:0];
            if (state == COL1 && xfer && !last1) kp1_addr <= kp1_addr + 12'd1;
            if (state == COL2 && xfer && !last2) kp2_addr <= kp2_addr + 12'd1;
`ifdef KPT_STREAM_CHECKSUM_EN
            if (xfer) csum_q <= csum_q ^ out_if.out_data;
`endif
        end
    end

    always_comb begin
        state_n          = state;
        out_if.out_valid = 1'b0;
        out_if.out_data  = '0;
        case (state)
            IDLE: if (start) state_n = HDR1;
            HDR1: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = {3'b001, n1_q};
                if (xfer) state_n = (n1_q != '0) ? RD1 : HDR2;
            end
            RD1:  state_n = ROW1;
            ROW1: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = {1'b1, 1'b0, 5'b0, kp1_rdata[18:10]};
                if (xfer) state_n = COL1;
            end
            COL1: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = {6'b0, col_q};
                if (xfer) state_n = last1 ? HDR2 : RD1;
            end
            HDR2: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = {3'b010, n2_q};
`ifdef KPT_STREAM_CHECKSUM_EN
                if (xfer) state_n = (n2_q != '0) ? RD2 : TRL;
`else
                if (xfer) state_n = (n2_q != '0) ? RD2 : FIN;
`endif
            end
            RD2:  state_n = ROW2;
            ROW2: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = {1'b1, 1'b1, 5'b0, kp2_rdata[18:10]};
                if (xfer) state_n = COL2;
            end
            COL2: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = {6'b0, col_q};
`ifdef KPT_STREAM_CHECKSUM_EN
                if (xfer) state_n = last2 ? TRL : RD2;
`else
                if (xfer) state_n = last2 ? FIN : RD2;
`endif
            end
`ifdef KPT_STREAM_CHECKSUM_EN
            TRL: begin
                out_if.out_valid = 1'b1;
                out_if.out_data  = csum_q;
                if (xfer) state_n = FIN;
            end
`endif
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule
